// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer:
// FSM state encoding, active-low 7-segment codes and digit clamping.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Segment order is gfedcba, active-low (0 lights a segment).
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Non-BCD nibbles in a loaded value saturate to 9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment decoder; codes 10-15 blank the display.
module seg7_decode
   import timer_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer: loads 00-99, decrements once per TICK_DIV
// RUN cycles, supports pause/resume, and pulses done when it reaches 00.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       running,
   output logic       done,
   output logic [6:0] hex1,
   output logic [6:0] hex0,
   output state_t     state_dbg
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   state_t        state;
   logic [PW-1:0] presc;

   assign state_dbg = state;

   // Handshake-free command interface: load, start and pause are sampled
   // every edge with priority load > start > pause; no acknowledge exists.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         tens    <= 4'd0;
         ones    <= 4'd0;
         presc   <= '0;
         done    <= 1'b0;
         running <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            tens    <= bcd_clamp(load_val[7:4]);
            ones    <= bcd_clamp(load_val[3:0]);
            presc   <= '0;
            state   <= IDLE;
            running <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (tens != 4'd0 || ones != 4'd0) begin
                        state   <= RUN;
                        presc   <= '0;
                        running <= 1'b1;
                     end else begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  // start is ignored here but still masks a simultaneous pause.
                  if (pause && !start) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end else if (presc == PRESC_MAX) begin
                     presc <= '0;
                     if (ones != 4'd0) begin
                        ones <= ones - 4'd1;
                     end else begin
                        ones <= 4'd9;
                        tens <= tens - 4'd1;
                     end
                     if (tens == 4'd0 && ones == 4'd1) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        running <= 1'b0;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               PAUSE: begin
                  if (start) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               DONE: begin
                  state <= DONE;
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

   seg7_decode u_seg_tens (
      .bcd (tens),
      .seg (hex1)
   );

   seg7_decode u_seg_ones (
      .bcd (ones),
      .seg (hex0)
   );

endmodule
